// File: rtl/req_ack_arbiter_if.sv
// Handshake bundle between requester agents, the round-robin arbiter and the shared resource.
interface req_ack_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned GW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic             res_req;
    logic             res_ack;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic             timeout_err;

    modport slave (
        input  req, res_ack,
        output ack, res_req, grant_id, busy, timeout_err
    );

    modport master (
        output req, res_ack,
        input  ack, res_req, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack resource among N_REQ requesters,
// with a watchdog that releases the resource if res_ack never arrives.
module req_ack_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    req_ack_arbiter_if.slave bus
);
    localparam int unsigned    GW      = $clog2(N_REQ);
    localparam int unsigned    WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  PTR_RST = GW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RES_REQ = 2'd1,
        HOLD    = 2'd2,
        RES_REL = 2'd3
    } state_t;

    state_t         state;
    logic [GW-1:0]  ptr;
    logic [WDW-1:0] wd;
    logic [GW-1:0]  pick_c;
    logic           pick_vld_c;

    // Walk downward so the last hit is the first requester after ptr (wrapping).
    always_comb begin
        pick_c     = '0;
        pick_vld_c = 1'b0;
        for (int i = int'(N_REQ); i >= 1; i--) begin
            if (bus.req[GW'((int'(ptr) + i) % int'(N_REQ))]) begin
                pick_c     = GW'((int'(ptr) + i) % int'(N_REQ));
                pick_vld_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= PTR_RST;
            wd              <= '0;
            bus.ack         <= '0;
            bus.res_req     <= 1'b0;
            bus.grant_id    <= '0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld_c) begin
                        bus.grant_id <= pick_c;
                        bus.res_req  <= 1'b1;
                        bus.busy     <= 1'b1;
                        wd           <= '0;
                        state        <= RES_REQ;
                    end
                end
                // res_ack is checked first so an ack on the expiry edge still wins.
                RES_REQ: begin
                    if (bus.res_ack) begin
                        bus.ack[bus.grant_id] <= 1'b1;
                        wd                    <= '0;
                        state                 <= HOLD;
                    end else if (wd == WD_LAST) begin
                        bus.timeout_err <= 1'b1;
                        bus.res_req     <= 1'b0;
                        wd              <= '0;
                        state           <= RES_REL;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                HOLD: begin
                    if (!bus.req[bus.grant_id]) begin
                        bus.ack     <= '0;
                        bus.res_req <= 1'b0;
                        state       <= RES_REL;
                    end
                end
                RES_REL: begin
                    if (!bus.res_ack) begin
                        ptr      <= bus.grant_id;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_req_ack_arbiter.sv
// Self-checking bench for req_ack_arbiter: requester and resource agents plus a grant-order scoreboard.
module tb_req_ack_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    req_ack_arbiter_if #(.N_REQ(N)) bus ();
    req_ack_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int cyc = 0;

    logic [N-1:0] prev_ack;
    logic         prev_rr, prev_to, prev_busy;
    bit           auto_drop;
    logic [N-1:0] rearm;
    bit           res_dead;
    int           res_delay, res_cnt;
    int t_rr_rise, t_rr_fall, t_ack_rise, t_ack_fall, t_to, t_req_drop, t_ra_rise, t_ra_fall, t_busy_fall;
    int t_drive, to_count, tc;
    bit ack_ever;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_marks();
        t_rr_rise = -1; t_rr_fall = -1; t_ack_rise = -1; t_ack_fall = -1; t_to = -1;
        t_req_drop = -1; t_ra_rise = -1; t_ra_fall = -1; t_busy_fall = -1;
    endtask

    // One cycle: sample on negedge, monitor/score, then drive the agents.
    task automatic step();
        logic [N-1:0] a;
        @(negedge clk);
        cyc++;
        a = bus.ack;
        if (a != '0) begin
            ack_ever = 1'b1;
            check("onehot0", int'($onehot0(a)), 1);
            check("ack_has_res_req", int'(bus.res_req), 1);
            check("ack_matches_gid", int'(a), 1 << bus.grant_id);
        end
        if (prev_ack == '0 && a != '0) begin
            if (t_ack_rise < 0) t_ack_rise = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_grant", int'(bus.grant_id), -1);
            end else begin
                int e = exp_q.pop_front();
                check("grant_order", int'(bus.grant_id), e);
            end
        end
        if (prev_ack != '0 && a == '0 && t_ack_fall < 0) t_ack_fall = cyc;
        if (!prev_rr && bus.res_req && t_rr_rise < 0) t_rr_rise = cyc;
        if (prev_rr && !bus.res_req && t_rr_fall < 0) t_rr_fall = cyc;
        if (prev_busy && !bus.busy && t_busy_fall < 0) t_busy_fall = cyc;
        if (bus.timeout_err) begin
            to_count++;
            if (t_to < 0) t_to = cyc;
            check("timeout_single_cycle", int'(prev_to), 0);
        end
        prev_ack  = a;
        prev_rr   = bus.res_req;
        prev_to   = bus.timeout_err;
        prev_busy = bus.busy;

        if (auto_drop) begin
            if ((bus.req & a) != '0 && t_req_drop < 0) t_req_drop = cyc;
            bus.req = (bus.req & ~a) | (rearm & ~a);
        end

        if (bus.res_req && !res_dead) begin
            res_cnt++;
            if (res_cnt >= res_delay && !bus.res_ack) begin
                bus.res_ack = 1'b1;
                if (t_ra_rise < 0) t_ra_rise = cyc;
            end
        end else if (!bus.res_req) begin
            if (bus.res_ack && t_ra_fall < 0) t_ra_fall = cyc;
            bus.res_ack = 1'b0;
            res_cnt     = 0;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.res_ack = 1'b0;
        res_cnt     = 0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        prev_ack  = '0;
        prev_rr   = 1'b0;
        prev_to   = 1'b0;
        prev_busy = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (!bus.busy && bus.req == '0 && !bus.res_ack && exp_q.size() == 0) return;
        end
        check(tag, 0, 1);
        exp_q.delete();
    endtask

    initial begin
        bus.req = '0; bus.res_ack = 1'b0; rst_n = 1'b0;
        auto_drop = 1'b1; rearm = '0; res_dead = 1'b0; res_delay = 3; res_cnt = 0;
        to_count = 0; ack_ever = 1'b0;
        clear_marks();
        do_reset();
        check("rst_ack", int'(bus.ack), 0);
        check("rst_res_req", int'(bus.res_req), 0);
        check("rst_grant_id", int'(bus.grant_id), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_timeout_err", int'(bus.timeout_err), 0);

        // Single requester 2, resource acks 3 cycles after res_req.
        step(); clear_marks();
        bus.req = 4'b0100; t_drive = cyc; exp_q.push_back(2);
        wait_idle(40, "single_wait_idle");
        check("single_res_req_latency", t_rr_rise - t_drive, 1);
        check("single_ack_latency", t_ack_rise - t_ra_rise, 1);
        check("single_ack_fall", t_ack_fall - t_req_drop, 1);
        check("single_res_req_fall", t_rr_fall - t_req_drop, 1);
        check("single_busy_fall", t_busy_fall - t_ra_fall, 1);
        check("single_grant_id", int'(bus.grant_id), 2);

        // Pointer at 2: wrap to 0 then 1.
        step(); clear_marks();
        bus.req = 4'b0011; exp_q.push_back(0); exp_q.push_back(1);
        wait_idle(60, "wrap_wait_idle");
        check("wrap_last_grant_id", int'(bus.grant_id), 1);

        // Dead resource: watchdog fires, then 0011 goes to 0 first.
        step(); clear_marks(); ack_ever = 1'b0; tc = to_count;
        res_dead = 1'b1; bus.req = 4'b0010;
        for (int i = 0; i < 40 && t_to < 0; i++) step();
        check("to_fired", int'(t_to >= 0), 1);
        check("to_latency", t_to - t_rr_rise, int'(TO));
        check("to_res_req_low", int'(bus.res_req), 0);
        check("to_no_ack", int'(ack_ever), 0);
        bus.req = 4'b0011; res_dead = 1'b0; res_delay = 2;
        exp_q.push_back(0); exp_q.push_back(1);
        wait_idle(60, "to_wait_idle");
        check("to_pulse_count", to_count - tc, 1);

        // res_ack lands on the watchdog expiry edge: ack wins.
        step(); clear_marks(); tc = to_count;
        res_delay = int'(TO); bus.req = 4'b0100; exp_q.push_back(2);
        wait_idle(60, "bnd_wait_idle");
        check("bnd_no_timeout", to_count - tc, 0);
        check("bnd_ack_edge", t_ack_rise - t_rr_rise, int'(TO));

        // Contention from reset with requesters re-arming after each ack.
        do_reset(); res_delay = 2;
        step(); clear_marks();
        rearm = 4'b1111; bus.req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
        for (int i = 0; i < 150 && exp_q.size() != 0; i++) step();
        check("contention_grants_left", exp_q.size(), 0);
        exp_q.delete();
        rearm = '0; bus.req = '0;
        wait_idle(40, "contention_wait_idle");

        // Asynchronous reset while requester 3 is in HOLD.
        do_reset(); res_delay = 2; auto_drop = 1'b0;
        step(); clear_marks();
        bus.req = 4'b1000; exp_q.push_back(3);
        for (int i = 0; i < 20 && !bus.ack[3]; i++) step();
        check("hold_ack3", int'(bus.ack[3]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("hold_rst_ack", int'(bus.ack), 0);
        check("hold_rst_res_req", int'(bus.res_req), 0);
        check("hold_rst_busy", int'(bus.busy), 0);
        check("hold_rst_grant_id", int'(bus.grant_id), 0);
        step();
        rst_n = 1'b1; auto_drop = 1'b1; bus.req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        wait_idle(150, "hold_rst_wait_idle");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
